sram_port_arbiter: RTL

- Shares one synchronous single-port SRAM between the fetch path (inst requester) and the load/store path (data requester).
- Grants at most one access per cycle. Data has priority over inst, with a starvation guard so fetch always makes progress.
- Routes the 1-cycle-latency read data back to the requester that issued the read.
- Sits between PC_calculator/fetch_stage and memory_stage on one side and the unified SRAM on the other.

---
 rtl/sram_port_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and load/store.
// Data wins by default; a streak counter forces a fetch grant after STARVE_LIMIT data wins.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [31:0]       inst_rdata,

    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [31:0]       data_rdata,

    output logic              sram_en,
    output logic [3:0]        sram_wen,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

    logic [3:0] streak_q, streak_d;
    logic       rd_pend_q, rd_pend_d;
    owner_e     rd_owner_q, rd_owner_d;
    logic       data_wins;

    // Data wins unless fetch is waiting and has already been passed over LIMIT times.
    assign data_wins = data_req && (!inst_req || (streak_q < LIMIT));
    assign data_gnt  = !reset && data_wins;
    assign inst_gnt  = !reset && inst_req && !data_wins;

    always_comb begin
        sram_en    = 1'b0;
        sram_wen   = 4'b0000;
        sram_addr  = '0;
        sram_wdata = 32'h0;
        if (data_gnt) begin
            sram_en    = 1'b1;
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_gnt) begin
            sram_en    = 1'b1;
            sram_addr  = inst_addr;
        end
    end

    always_comb begin
        streak_d = 4'd0;
        if (data_gnt && inst_req) begin
            streak_d = (streak_q == LIMIT) ? LIMIT : streak_q + 4'd1;
        end
    end

    always_comb begin
        rd_pend_d  = inst_gnt || (data_gnt && (data_wen == 4'b0000));
        rd_owner_d = rd_owner_q;
        if (data_gnt && (data_wen == 4'b0000)) begin
            rd_owner_d = OWN_DATA;
        end else if (inst_gnt) begin
            rd_owner_d = OWN_INST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q   <= 4'd0;
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_INST;
        end else begin
            streak_q   <= streak_d;
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // The SRAM returns read data one cycle after the enabled read; steer it by owner.
    assign inst_rvalid = rd_pend_q && (rd_owner_q == OWN_INST);
    assign data_rvalid = rd_pend_q && (rd_owner_q == OWN_DATA);
    assign inst_rdata  = sram_rdata;
    assign data_rdata  = sram_rdata;

    a_one_gnt : assert property (@(posedge clk) disable iff (reset) !(inst_gnt && data_gnt));
    a_one_rvalid : assert property (@(posedge clk) disable iff (reset) !(inst_rvalid && data_rvalid));

endmodule
